// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: widths, MEM-stage FSM encoding, MEM/WB control bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

  localparam int DW          = 32;
  localparam int REG_ADDR_W  = 5;
  localparam int TIMEOUT_CYC = 16;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_t;

  // Control half of the MEM/WB register; data fields stay separate so DW can vary.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rw;
    logic                  reg_wr;
    logic                  memto_reg;
  } mw_ctrl_t;

  // True when the low address bits select a whole word.
  function automatic logic word_aligned(input logic [1:0] lsb);
    return (lsb == 2'b00);
  endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register with load and bubble control.
// Latency: 1 cycle from ld to outputs.
// Backpressure: when ld is low the write enable is cleared (bubble) and all other fields hold.
module mem_wb_reg #(
  parameter int DW = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           ld,
  input  logic                           ld_mdata,
  input  logic [DW-1:0]                  alu_in,
  input  logic [DW-1:0]                  mdata_in,
  input  logic [cpu_pkg::REG_ADDR_W-1:0] rw_in,
  input  logic                           reg_wr_in,
  input  logic                           memto_reg_in,
  output logic [DW-1:0]                  alu_out,
  output logic [DW-1:0]                  mdata_out,
  output logic [cpu_pkg::REG_ADDR_W-1:0] rw_out,
  output logic                           reg_wr_out,
  output logic                           memto_reg_out
);
  import cpu_pkg::*;

  mw_ctrl_t      ctrl_q;
  logic [DW-1:0] alu_q;
  logic [DW-1:0] mdata_q;

  // Capture a retiring instruction, otherwise insert a write-back bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q  <= '0;
      alu_q   <= '0;
      mdata_q <= '0;
    end else if (ld) begin
      alu_q            <= alu_in;
      ctrl_q.rw        <= rw_in;
      ctrl_q.reg_wr    <= reg_wr_in;
      ctrl_q.memto_reg <= memto_reg_in;
      if (ld_mdata) begin
        mdata_q <= mdata_in;
      end
    end else begin
      ctrl_q.reg_wr <= 1'b0;
    end
  end

  assign alu_out       = alu_q;
  assign mdata_out     = mdata_q;
  assign rw_out        = ctrl_q.rw;
  assign reg_wr_out    = ctrl_q.reg_wr;
  assign memto_reg_out = ctrl_q.memto_reg;

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: data-memory req/ack access, branch resolve, MEM/WB register; MEM_ALIGN_CHECK_EN adds misalignment faulting.
// Latency: non-memory ops 1 cycle; memory ops 1 issue cycle plus cycles until ack (bounded by TIMEOUT_CYC).
// Backpressure: stall holds upstream while a request is being issued or awaits ack; timeout releases it with bus_err.
module mem_stage #(
  parameter int DW          = cpu_pkg::DW,
  parameter int TIMEOUT_CYC = cpu_pkg::TIMEOUT_CYC
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [DW-1:0]                  NewPC,
  input  logic                           Zero,
  input  logic                           Overflow,
  input  logic [DW-1:0]                  ALUout,
  input  logic [cpu_pkg::REG_ADDR_W-1:0] Rw,
  input  logic                           MemWr,
  input  logic                           Branch,
  input  logic                           MemtoReg,
  input  logic                           RegWr,
  input  logic [DW-1:0]                  busB,
  output logic                           stall,
  output logic                           pc_src,
  output logic [DW-1:0]                  pc_target,
  output logic                           dmem_req,
  output logic                           dmem_we,
  output logic [DW-1:0]                  dmem_addr,
  output logic [DW-1:0]                  dmem_wdata,
  input  logic [DW-1:0]                  dmem_rdata,
  input  logic                           dmem_ack,
  output logic [DW-1:0]                  mw_ALUout,
  output logic [DW-1:0]                  mw_MemData,
  output logic [cpu_pkg::REG_ADDR_W-1:0] mw_Rw,
  output logic                           mw_RegWr,
  output logic                           mw_MemtoReg,
  output logic                           bus_err
);
  import cpu_pkg::*;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

  mem_state_t state;
  logic [7:0] cnt;

  logic mem_op;
  logic misalign;
  logic issue;
  logic timeout;
  logic ack_done;
  logic retire;
  logic wb_reg_wr;
  logic wb_ld_mdata;

  assign mem_op = MemWr | MemtoReg;

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = mem_op & ~word_aligned(ALUout[1:0]);
`else
  assign misalign = 1'b0;
`endif

  // A memory op sitting in IDLE launches a request unless it faults on alignment.
  assign issue    = (state == IDLE) & mem_op & ~misalign;
  assign timeout  = (state == ACCESS) & (cnt == CNT_LAST);
  assign ack_done = (state == ACCESS) & dmem_ack;
  assign stall    = issue | ((state == ACCESS) & ~dmem_ack & ~timeout);

  // Branch resolution is purely combinational and never waits on memory.
  assign pc_src    = Branch & Zero;
  assign pc_target = NewPC;

  // The MEM/WB register loads when the instruction leaves this stage with a result;
  // a timeout leaves it as a bubble.
  assign retire      = ((state == IDLE) & ~issue) | ack_done;
  assign wb_reg_wr   = RegWr & ~Overflow & ~misalign;
  assign wb_ld_mdata = ack_done & MemtoReg;

  // Access FSM: issue, hold the request stable, finish on ack or abort on timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      bus_err    <= 1'b0;
    end else begin
      bus_err <= 1'b0;
      if (state == IDLE) begin
        if (issue) begin
          state      <= ACCESS;
          cnt        <= '0;
          dmem_req   <= 1'b1;
          dmem_we    <= MemWr;
          dmem_addr  <= ALUout;
          dmem_wdata <= busB;
        end else if (misalign) begin
          bus_err <= 1'b1;
        end
      end else begin
        if (dmem_ack) begin
          state    <= IDLE;
          dmem_req <= 1'b0;
          dmem_we  <= 1'b0;
        end else if (timeout) begin
          state    <= IDLE;
          dmem_req <= 1'b0;
          dmem_we  <= 1'b0;
          bus_err  <= 1'b1;
        end else if (cnt != CNT_LAST) begin
          cnt <= cnt + 8'd1;
        end
      end
    end
  end

  mem_wb_reg #(.DW(DW)) u_mem_wb_reg (
    .clk           (clk),
    .rst           (rst),
    .ld            (retire),
    .ld_mdata      (wb_ld_mdata),
    .alu_in        (ALUout),
    .mdata_in      (dmem_rdata),
    .rw_in         (Rw),
    .reg_wr_in     (wb_reg_wr),
    .memto_reg_in  (MemtoReg),
    .alu_out       (mw_ALUout),
    .mdata_out     (mw_MemData),
    .rw_out        (mw_Rw),
    .reg_wr_out    (mw_RegWr),
    .memto_reg_out (mw_MemtoReg)
  );

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM pipeline stage. Consumes the EX/MEM register outputs and performs the data-memory load or store through a req/ack handshake.
- Resolves branches. Stalls upstream while an access is outstanding.
- Produces the MEM/WB pipeline register that feeds write-back.
- Sits between the EX/MEM register and the register-file write port.

Parameters:
DW, 32, data/address width
TIMEOUT_CYC, 16, max cycles waiting for dmem_ack before aborting (range 2..255)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
NewPC  in  DW  branch target from EX/MEM
Zero  in  1  ALU zero flag
Overflow  in  1  ALU overflow flag
ALUout  in  DW  ALU result / memory address
Rw  in  5  destination register
MemWr  in  1  store
Branch  in  1  branch instruction
MemtoReg  in  1  load (result comes from memory)
RegWr  in  1  register write enable
busB  in  DW  store data
stall  out  1  freeze IF/ID/EX and EX/MEM while high
pc_src  out  1  branch taken (Branch & Zero), combinational
pc_target  out  DW  = NewPC, combinational
dmem_req  out  1  memory request, registered
dmem_we  out  1  write strobe, valid with dmem_req
dmem_addr  out  DW  address, valid with dmem_req
dmem_wdata  out  DW  store data
dmem_rdata  in  DW  load data, sampled when dmem_ack
dmem_ack  in  1  access complete
mw_ALUout  out  DW  MEM/WB ALU result
mw_MemData  out  DW  MEM/WB load data
mw_Rw  out  5  MEM/WB destination
mw_RegWr  out  1  MEM/WB write enable
mw_MemtoReg  out  1  MEM/WB select
bus_err  out  1  one-cycle pulse on timeout

Behaviour:
- Reset (synchronous, active-high):
  - FSM state IDLE, timeout counter 0.
  - All registered outputs 0: dmem_req, dmem_we, dmem_addr, dmem_wdata, every mw_* output, bus_err.
  - stall is 0 in IDLE.
- FSM states:
  - IDLE, no access in flight.
  - IDLE -> ACCESS when mem_op = MemWr | MemtoReg. On that edge: dmem_req=1, dmem_we=MemWr, dmem_addr=ALUout, dmem_wdata=busB, counter=0.
  - In ACCESS: dmem_req, dmem_we, dmem_addr and dmem_wdata hold stable until the access completes.
  - ACCESS with dmem_ack=1 -> IDLE. dmem_req drops the next edge. A load captures dmem_rdata into mw_MemData.
  - ACCESS with counter = TIMEOUT_CYC-1 and no ack -> IDLE. bus_err=1 for one cycle. mw_RegWr forced to 0.
  - ACK and timeout on the same cycle: ack wins, no bus_err.
- stall = (state==IDLE & mem_op) | (state==ACCESS & ~dmem_ack & ~timeout). Combinational. Upstream registers hold their values while stall is high.
- MEM/WB update:
  - Non-memory instruction in IDLE: updates every cycle, latency 1.
  - Memory instruction: updates on the completing edge only.
  - While stall is high, mw_RegWr=0 (bubble) and the other mw_* fields hold.
- mw_RegWr = RegWr & ~Overflow. An overflowing instruction never writes the register file.
- A store never writes a register: mw_RegWr follows RegWr from decode, mw_MemtoReg=0.
- Branch & Zero asserts pc_src in the same cycle, independent of the FSM. A branch does not stall.
- Reset while in ACCESS aborts the access: dmem_req=0 on the next edge, no bus_err.
- The counter saturates and never wraps.
- No write to memory occurs when rst=1.

Optional Feature:
- MEM_ALIGN_CHECK_EN
- When defined: a mem_op with ALUout[1:0] != 0 issues no request. It pulses bus_err for one cycle, forces mw_RegWr=0 and completes in 1 cycle with no stall.
- When undefined: no check is made. dmem_addr passes through unmodified and the access proceeds normally.

Decomposition:
- Shared package cpu_pkg holds:
  - DW
  - REG_ADDR_W=5
  - FSM state encoding mem_state_t {IDLE=1'b0, ACCESS=1'b1}
  - default TIMEOUT_CYC
- One natural sub-module: mem_wb_reg, the MEM/WB pipeline register with load/bubble controls, reused by hazard logic later.

Test Plan:
1. Reset: rst=1 for 2 cycles mid-ACCESS -> dmem_req=0, all mw_*=0, stall=0, bus_err never pulses.
2. ALU op (RegWr=1, Rw=5, ALUout=0x1234): next edge mw_Rw=5, mw_ALUout=0x1234, mw_RegWr=1, stall=0 throughout.
3. Load with addr 0x40, ack after 3 cycles, dmem_rdata=0xDEADBEEF:
   - stall high for 4 cycles; dmem_addr=0x40 stable.
   - mw_MemData=0xDEADBEEF, mw_MemtoReg=1, mw_RegWr=1.
4. Store with busB=0xA5A5A5A5, addr 0x80, ack same cycle as first req:
   - dmem_we=1, dmem_wdata=0xA5A5A5A5, one stall cycle per access.
   - mw_RegWr=0.
5. Load, never acked, TIMEOUT_CYC=16 -> bus_err single pulse at cycle 16 of ACCESS, mw_RegWr=0, stall released.
6. Branch=1, Zero=1, NewPC=0x100 -> pc_src=1, pc_target=0x100 same cycle. With Overflow=1 and RegWr=1 -> mw_RegWr=0.
